transaction_draw_sequencer: RTL and testbench
=============================================

# transaction_draw_sequencer

Controller for one transaction animation frame in the visual pipeline. It erases a rectangular region, starts the transaction drawer, and forwards the drawer's pixel stream to the VGA adapter. It then holds for a frame delay and signals completion. It sits upstream of the drawer, supplying its start point, reset and enable, and downstream of it, consuming its coordinate stream and done flag, in front of the VGA adapter's plot port.

## Interface
- REGION_W, 128: clear-region width in pixels.
- REGION_H, 32: clear-region height in pixels.
- Y_OFFSET, 8: rows the region extends above base_y.
- FRAME_TICKS, 833333: hold cycles after drawing (60 Hz at 50 MHz).
- DRAW_MAX, 16384: maximum DRAW cycles before timeout.
- BG_COLOUR, 3'b000: erase colour.
- clk in 1: clock.
- resetn in 1: reset, synchronous, active-low.
- go in 1: start request, sampled only in IDLE.
- base_x in 9: region/drawer origin x.
- base_y in 8: drawer origin y.
- fg_colour in 3: colour for drawer pixels; sampled with go.
- drw_resetn out 1: drawer reset (active-low).
- drw_enable out 1: drawer step enable.
- drw_start_x out 9: latched base_x.
- drw_start_y out 8: latched base_y.
- drw_x in 9: drawer x coordinate.
- drw_y in 8: drawer y coordinate.
- drw_done in 1: drawer finished.
- vga_x out 9: plot x, registered.
- vga_y out 8: plot y, registered.
- vga_colour out 3: plot colour, registered.
- vga_plot out 1: plot strobe, registered.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse at end of sequence.
- err out 1: sticky drawer timeout, cleared on the next accepted go.

## Operation
- States: IDLE, CLEAR, DRW_RST, DRAW, HOLD, FIN.
- **IDLE**
  - On a go edge, latch base_x, base_y and fg_colour, clear cx, cy and err, and move to CLEAR.
  - go in any other state is ignored.
- **CLEAR**
  - One pixel per cycle, raster order: cx runs 0..REGION_W-1, and cy increments when cx wraps.
  - Pixel is (bx+cx, by-Y_OFFSET+cy) in BG_COLOUR.
  - Arithmetic is modulo 2^9 for x and 2^8 for y; no clipping.
  - After pixel (REGION_W-1, REGION_H-1), move to DRW_RST.
- **DRW_RST**
  - Exactly one cycle with drw_resetn=0, so the drawer captures its start point.
  - drw_resetn = resetn AND NOT(state==DRW_RST).
- **DRAW**
  - drw_enable=1; each cycle forward drw_x and drw_y with the latched fg_colour and plot=1.
  - When drw_done=1 is sampled: move to HOLD, set drw_enable=0 from the next cycle, and plot nothing for that sample.
  - A DRAW cycle counter reaching DRAW_MAX sets err and moves to HOLD.
- **HOLD**: count FRAME_TICKS cycles with plot=0, then move to FIN.
- **FIN**: done=1 for one cycle, then IDLE.
- drw_start_x and drw_start_y are constant from latch until the next accepted go.

## Timing
- Reset values: state IDLE; vga_x, vga_y, vga_colour, vga_plot, drw_enable, busy, done and err all 0; drw_resetn 0 while resetn=0.
- Reset mid-operation aborts on the next edge with no final pixel and no done.
- go sampled at edge k: busy=1 after k, and the first CLEAR pixel is on vga after k+1.
- vga outputs lag the state and counters by one register stage.
- CLEAR occupies exactly REGION_W*REGION_H cycles, and exactly that many plot strobes appear.
- DRW_RST is one cycle; DRAW starts at the next edge.
- drw_done sampled at edge m: drw_enable=0 after m, and vga_plot=0 after m+1.
- HOLD lasts FRAME_TICKS cycles; FIN lasts 1 cycle.
- go held high continuously restarts one cycle after FIN (IDLE sampled once).

## Test plan
- **Basic sequence:** REGION 4x2, Y_OFFSET 1, FRAME_TICKS 3; base (10,20), fg 3'b010, drawer model done after 5 cycles.
  - 8 BG plots at x 10..13, y 19..20.
  - One drw_resetn low cycle.
  - 5 plots with colour 3'b010.
  - Then 3 idle cycles, done pulse, busy low.
- **Wrap:** base (510,0), REGION 4x2, Y_OFFSET 1 → x sequence 510, 511, 0, 1 and y values 255 then 0.
- **Ignored go:** pulse go during CLEAR and during HOLD → no restart, single done pulse, latched start unchanged.
- **Timeout:** drw_done held 0, DRAW_MAX 16 → exactly 16 DRAW plots, err=1 through FIN, err cleared on the next go.
- **Reset mid-CLEAR:** resetn=0 at pixel 3 → all outputs 0 the next cycle, no done; a new go restarts from cx=cy=0.
- **Back-to-back:** go tied high → second CLEAR starts one cycle after the first FIN, with new base values latched.

Source files
------------

// File: rtl/transaction_draw_sequencer.sv
// transaction_draw_sequencer
//   Sequences one transaction animation frame: erases a rectangular region
//   behind the drawer's origin, pulses the drawer's reset so it captures its
//   start point, and forwards the drawer's pixel stream to the VGA plot port
//   until the drawer finishes or times out. It then holds for one frame
//   period and pulses done.
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   go                    start request (accepted only while idle)
//   base_x, base_y        region / drawer origin
//   fg_colour             colour for drawer pixels (latched with go)
//   drw_resetn            drawer reset, low for one cycle before drawing
//   drw_enable            drawer step enable
//   drw_start_x/_y        latched origin presented to the drawer
//   drw_x, drw_y          drawer coordinate stream
//   drw_done              drawer finished flag
//   vga_x, vga_y          registered plot coordinates
//   vga_colour, vga_plot  registered plot colour and strobe
//   busy                  high whenever a sequence is in progress
//   done                  one-cycle end-of-sequence pulse
//   err                   sticky drawer timeout, cleared by the next go

module transaction_draw_sequencer #(
   parameter int unsigned REGION_W    = 128,
   parameter int unsigned REGION_H    = 32,
   parameter int unsigned Y_OFFSET    = 8,
   parameter int unsigned FRAME_TICKS = 833333,
   parameter int unsigned DRAW_MAX    = 16384,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [8:0] base_x,
   input  logic [7:0] base_y,
   input  logic [2:0] fg_colour,
   output logic       drw_resetn,
   output logic       drw_enable,
   output logic [8:0] drw_start_x,
   output logic [7:0] drw_start_y,
   input  logic [8:0] drw_x,
   input  logic [7:0] drw_y,
   input  logic       drw_done,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CXW = (REGION_W > 1) ? $clog2(REGION_W) : 1;
   localparam int unsigned CYW = (REGION_H > 1) ? $clog2(REGION_H) : 1;
   localparam int unsigned DCW = $clog2(DRAW_MAX + 1);
   localparam int unsigned HCW = $clog2(FRAME_TICKS + 1);

   localparam logic [CXW-1:0] CX_LAST = CXW'(REGION_W - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(REGION_H - 1);
   localparam logic [DCW-1:0] DC_LAST = DCW'(DRAW_MAX - 1);
   localparam logic [HCW-1:0] HC_LAST = HCW'(FRAME_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      DRW_RST,
      DRAW,
      HOLD,
      FIN
   } state_t;

   state_t state, state_nxt;

   logic [8:0]     bx;
   logic [7:0]     by;
   logic [2:0]     fg;
   logic [CXW-1:0] cx;
   logic [CYW-1:0] cy;
   logic [DCW-1:0] dcnt;
   logic [HCW-1:0] hcnt;

   logic clear_last;
   logic draw_last;
   logic hold_last;

   assign clear_last = (cx == CX_LAST) && (cy == CY_LAST);
   assign draw_last  = (dcnt == DC_LAST);
   assign hold_last  = (hcnt == HC_LAST);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // Next state and state-decoded outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      busy       = 1'b1;
      done       = 1'b0;
      drw_enable = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (go) state_nxt = CLEAR;
         end
         CLEAR: begin
            if (clear_last) state_nxt = DRW_RST;
         end
         DRW_RST: begin
            state_nxt = DRAW;
         end
         DRAW: begin
            drw_enable = 1'b1;
            // done has priority; the timeout still lets its own pixel through
            if (drw_done || draw_last) state_nxt = HOLD;
         end
         HOLD: begin
            if (hold_last) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The drawer is held in reset with the system and for the single
   // DRW_RST cycle, where it captures drw_start_x/drw_start_y.
   assign drw_resetn  = resetn & (state != DRW_RST);
   assign drw_start_x = bx;
   assign drw_start_y = by;

   // ---------------------------------------------------------------------
   // Datapath: latched request, counters and the registered plot port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bx         <= '0;
         by         <= '0;
         fg         <= '0;
         cx         <= '0;
         cy         <= '0;
         dcnt       <= '0;
         hcnt       <= '0;
         err        <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         vga_plot <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  bx  <= base_x;
                  by  <= base_y;
                  fg  <= fg_colour;
                  cx  <= '0;
                  cy  <= '0;
                  err <= 1'b0;
               end
            end
            CLEAR: begin
               // Region sits Y_OFFSET rows above base_y; x and y wrap
               // naturally at their port widths.
               vga_x      <= bx + 9'(cx);
               vga_y      <= by - 8'(Y_OFFSET) + 8'(cy);
               vga_colour <= BG_COLOUR;
               vga_plot   <= 1'b1;
               if (cx == CX_LAST) begin
                  cx <= '0;
                  cy <= cy + 1'b1;
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            DRW_RST: begin
               dcnt <= '0;
               hcnt <= '0;
            end
            DRAW: begin
               dcnt <= dcnt + 1'b1;
               if (!drw_done) begin
                  vga_x      <= drw_x;
                  vga_y      <= drw_y;
                  vga_colour <= fg;
                  vga_plot   <= 1'b1;
                  if (draw_last) err <= 1'b1;
               end
            end
            HOLD: begin
               hcnt <= hcnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transaction_draw_sequencer.sv
// Directed bench for transaction_draw_sequencer using a small 4x2 region,
// a three-cycle frame hold and a 16-cycle draw limit. A behavioural drawer
// steps one pixel diagonally per enabled cycle and finishes after 5 steps
// unless no_done is set.

module tb_transaction_draw_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       go;
   logic [8:0] base_x;
   logic [7:0] base_y;
   logic [2:0] fg_colour;
   logic       drw_resetn;
   logic       drw_enable;
   logic [8:0] drw_start_x;
   logic [7:0] drw_start_y;
   logic [8:0] drw_x;
   logic [7:0] drw_y;
   logic       drw_done;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;
   logic       err;

   int passed = 0;
   int total  = 0;

   logic [8:0] exp_x [8];
   logic [7:0] exp_y [8];

   // drawer model
   logic       no_done = 1'b0;
   logic [8:0] m_sx;
   logic [7:0] m_sy;
   logic [7:0] m_cnt;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!drw_resetn) begin
         m_cnt <= 8'd0;
         m_sx  <= drw_start_x;
         m_sy  <= drw_start_y;
      end else if (drw_enable) begin
         m_cnt <= m_cnt + 8'd1;
      end
   end

   assign drw_x    = m_sx + 9'(m_cnt);
   assign drw_y    = m_sy + m_cnt;
   assign drw_done = !no_done && (m_cnt == 8'd5);

   transaction_draw_sequencer #(
      .REGION_W   (4),
      .REGION_H   (2),
      .Y_OFFSET   (1),
      .FRAME_TICKS(3),
      .DRAW_MAX   (16),
      .BG_COLOUR  (3'b000)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .go         (go),
      .base_x     (base_x),
      .base_y     (base_y),
      .fg_colour  (fg_colour),
      .drw_resetn (drw_resetn),
      .drw_enable (drw_enable),
      .drw_start_x(drw_start_x),
      .drw_start_y(drw_start_y),
      .drw_x      (drw_x),
      .drw_y      (drw_y),
      .drw_done   (drw_done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full frame starting from IDLE. Clear-pixel expectations come from
   // exp_x/exp_y. Returns just after the edge that enters FIN.
   task automatic frame(input logic [8:0] bx, input logic [7:0] by, input logic [2:0] col,
                        input bit tmo, input bit noise, input bit keep);
      int n;
      logic [8:0] ex;
      logic [7:0] ey;
      base_x    = bx;
      base_y    = by;
      fg_colour = col;
      no_done   = tmo;
      go        = 1'b1;
      tick();
      if (!keep) go = 1'b0;
      check("busy_after_go", busy, 1);
      check("err_cleared_on_go", err, 0);
      check("no_plot_after_go", vga_plot, 0);
      for (int i = 0; i < 8; i++) begin
         if (noise && i == 2) begin
            go        = 1'b1;
            base_x    = 9'd77;
            base_y    = 8'd99;
            fg_colour = 3'b111;
         end
         tick();
         if (noise && i == 2) go = keep;
         check("clear_plot", vga_plot, 1);
         check("clear_x", vga_x, exp_x[i]);
         check("clear_y", vga_y, exp_y[i]);
         check("clear_colour", vga_colour, 3'b000);
      end
      check("drw_resetn_low", drw_resetn, 0);
      check("enable_in_rst", drw_enable, 0);
      tick();
      check("drw_resetn_high", drw_resetn, 1);
      check("no_plot_in_rst", vga_plot, 0);
      check("enable_in_draw", drw_enable, 1);
      check("start_x", drw_start_x, bx);
      check("start_y", drw_start_y, by);
      n = tmo ? 16 : 5;
      for (int j = 0; j < n; j++) begin
         tick();
         ex = bx + 9'(j);
         ey = by + 8'(j);
         check("draw_plot", vga_plot, 1);
         check("draw_x", vga_x, ex);
         check("draw_y", vga_y, ey);
         check("draw_colour", vga_colour, col);
      end
      if (!tmo) begin
         tick();
         check("enable_off_after_done", drw_enable, 0);
         check("no_plot_for_done", vga_plot, 0);
         check("err_no_timeout", err, 0);
      end else begin
         check("enable_off_after_timeout", drw_enable, 0);
         check("err_timeout", err, 1);
      end
      for (int h = 0; h < 2; h++) begin
         if (noise && h == 0) begin
            go     = 1'b1;
            base_x = 9'd55;
         end
         tick();
         if (noise && h == 0) go = keep;
         check("hold_no_done", done, 0);
         check("hold_no_plot", vga_plot, 0);
         check("hold_busy", busy, 1);
      end
      tick();
      check("fin_done", done, 1);
      check("fin_busy", busy, 1);
      check("fin_err", err, tmo);
      check("fin_start_x", drw_start_x, bx);
   endtask

   initial begin
      resetn    = 1'b0;
      go        = 1'b0;
      base_x    = '0;
      base_y    = '0;
      fg_colour = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_plot", vga_plot, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_enable", drw_enable, 0);
      check("rst_drw_resetn", drw_resetn, 0);
      resetn = 1'b1;
      tick();
      check("idle_drw_resetn", drw_resetn, 1);

      // basic sequence, with ignored go pulses in CLEAR and HOLD
      exp_x = '{9'd10, 9'd11, 9'd12, 9'd13, 9'd10, 9'd11, 9'd12, 9'd13};
      exp_y = '{8'd19, 8'd19, 8'd19, 8'd19, 8'd20, 8'd20, 8'd20, 8'd20};
      frame(9'd10, 8'd20, 3'b010, 1'b0, 1'b1, 1'b0);
      tick();
      check("after_fin_done", done, 0);
      check("after_fin_busy", busy, 0);
      tick();
      check("no_restart", busy, 0);

      // coordinate wrap
      exp_x = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd510, 9'd511, 9'd0, 9'd1};
      exp_y = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
      frame(9'd510, 8'd0, 3'b110, 1'b0, 1'b0, 1'b0);
      tick();

      // drawer timeout; err sticky in IDLE until next go
      exp_x = '{9'd40, 9'd41, 9'd42, 9'd43, 9'd40, 9'd41, 9'd42, 9'd43};
      exp_y = '{8'd99, 8'd99, 8'd99, 8'd99, 8'd100, 8'd100, 8'd100, 8'd100};
      frame(9'd40, 8'd100, 3'b011, 1'b1, 1'b0, 1'b0);
      tick();
      check("err_sticky_idle", err, 1);
      frame(9'd40, 8'd100, 3'b101, 1'b0, 1'b0, 1'b0);
      tick();

      // reset in the middle of CLEAR
      base_x    = 9'd30;
      base_y    = 8'd40;
      fg_colour = 3'b001;
      go        = 1'b1;
      tick();
      go = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("midclr_x3", vga_x, 9'd33);
      resetn = 1'b0;
      tick();
      check("abort_plot", vga_plot, 0);
      check("abort_x", vga_x, 0);
      check("abort_y", vga_y, 0);
      check("abort_colour", vga_colour, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_enable", drw_enable, 0);
      check("abort_drw_resetn", drw_resetn, 0);
      resetn = 1'b1;
      tick();
      check("abort_stays_idle", busy, 0);
      exp_x = '{9'd30, 9'd31, 9'd32, 9'd33, 9'd30, 9'd31, 9'd32, 9'd33};
      exp_y = '{8'd39, 8'd39, 8'd39, 8'd39, 8'd40, 8'd40, 8'd40, 8'd40};
      frame(9'd30, 8'd40, 3'b001, 1'b0, 1'b0, 1'b0);
      tick();

      // back-to-back with go held high
      exp_x = '{9'd100, 9'd101, 9'd102, 9'd103, 9'd100, 9'd101, 9'd102, 9'd103};
      exp_y = '{8'd49, 8'd49, 8'd49, 8'd49, 8'd50, 8'd50, 8'd50, 8'd50};
      frame(9'd100, 8'd50, 3'b001, 1'b0, 1'b0, 1'b1);
      tick();
      check("b2b_idle_once", busy, 0);
      check("b2b_done_low", done, 0);
      exp_x = '{9'd200, 9'd201, 9'd202, 9'd203, 9'd200, 9'd201, 9'd202, 9'd203};
      exp_y = '{8'd59, 8'd59, 8'd59, 8'd59, 8'd60, 8'd60, 8'd60, 8'd60};
      frame(9'd200, 8'd60, 3'b100, 1'b0, 1'b0, 1'b1);
      go = 1'b0;
      tick();
      check("end_busy", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
